instruction_fetch: RTL and testbench

Fetch stage of the RISC-V datapath: owns the program counter, drives the word address into `instruction_memory`, and pairs each returned instruction with its PC for the decode stage. It accounts for the memory's one-cycle registered read latency, holds output under decode back-pressure, and flushes on a redirect from execute (taken branch, JAL/JALR). It sustains one instruction per cycle.

---
 rtl/instruction_fetch_if.sv | 40 ++++
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Fetch-stage bus: instruction memory port, execute redirect,
//               and the decode hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    logic [63:0] read_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        id_ready;

    modport master (
        output read_address,
        output if_valid,
        output if_pc,
        output if_instruction,
        input  instruction,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready
    );

    modport slave (
        input  read_address,
        input  if_valid,
        input  if_pc,
        input  if_instruction,
        output instruction,
        output redirect_valid,
        output redirect_pc,
        output id_ready
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : RISC-V fetch stage; tracks one request in flight through a
//               registered-read memory and holds its output under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instruction_fetch_if.master bus
);

    localparam logic [63:0] c_RESET_PC_ALIGNED = RESET_PC & ~64'h3;

    logic [63:0] pc_q, pc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_pc_q, rsp_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        accept;

    assign accept = !out_valid_q || bus.id_ready;

    // During a stall the in-flight address is re-presented so the registered
    // memory output keeps showing the response we still owe the output slot.
    always_comb begin
        if (accept || !rsp_valid_q) begin
            bus.read_address = {2'b00, pc_q[63:2]};
        end else begin
            bus.read_address = {2'b00, rsp_pc_q[63:2]};
        end
    end

    always_comb begin
        pc_d        = pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        if (bus.redirect_valid) begin
            pc_d        = {bus.redirect_pc[63:2], 2'b00};
            rsp_valid_d = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = rsp_valid_q;
            out_pc_d    = rsp_pc_q;
            out_instr_d = bus.instruction;
            rsp_valid_d = 1'b1;
            rsp_pc_d    = pc_q;
            pc_d        = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= c_RESET_PC_ALIGNED;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= 64'h0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 64'h0;
            out_instr_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign bus.if_valid       = out_valid_q;
    assign bus.if_pc          = out_pc_q;
    assign bus.if_instruction = out_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    instruction_fetch_if fb ();

    instruction_fetch #(
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] w);
        return 32'hC0DE_0000 | {16'h0, w[15:0]};
    endfunction

    // Registered-read instruction memory model
    always @(posedge clk) fb.instruction <= memf(fb.read_address);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] pc);
        check({tag, "_valid"}, {63'h0, fb.if_valid}, 64'h1);
        check({tag, "_pc"}, fb.if_pc, pc);
        check({tag, "_instr"}, {32'h0, fb.if_instruction}, {32'h0, memf({2'b00, pc[63:2]})});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {63'h0, fb.if_valid}, 64'h0);
    endtask

    task automatic redirect(input logic [63:0] target);
        fb.redirect_valid = 1'b1;
        fb.redirect_pc    = target;
        tick();
        fb.redirect_valid = 1'b0;
        fb.redirect_pc    = 64'h0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        reset             = 1'b1;
        fb.redirect_valid = 1'b0;
        fb.redirect_pc    = 64'h0;
        fb.id_ready       = 1'b1;

        repeat (3) tick();
        expect_idle("rst");
        check("rst_pc", fb.if_pc, 64'h0);
        check("rst_instr", {32'h0, fb.if_instruction}, 64'h0);
        check("rst_raddr", fb.read_address, 64'h0);

        reset = 1'b0;
        tick(); expect_idle("e0");
        tick(); expect_out("s0", 64'h0);
        tick(); expect_out("s4", 64'h4);
        tick(); expect_out("s8", 64'h8);

        fb.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall", 64'h8);
            check("stall_raddr", fb.read_address, 64'h3);
        end
        fb.id_ready = 1'b1;
        tick(); expect_out("rel12", 64'hC);
        tick(); expect_out("rel16", 64'h10);
        tick(); expect_out("s20", 64'h14);
        tick(); expect_out("s24", 64'h18);

        redirect(64'h40);
        expect_idle("redir_b1");
        tick(); expect_idle("redir_b2");
        tick(); expect_out("redir40", 64'h40);
        tick(); expect_out("redir44", 64'h44);

        fb.id_ready = 1'b0;
        tick(); expect_out("hold44", 64'h44);
        redirect(64'h13);
        expect_idle("sredir_b1");
        tick(); expect_idle("sredir_b2");
        tick(); expect_out("sredir10", 64'h10);
        tick(); expect_out("sredir10_hold", 64'h10);
        fb.id_ready = 1'b1;
        tick(); expect_out("sredir14", 64'h14);

        reset             = 1'b1;
        fb.redirect_valid = 1'b1;
        fb.redirect_pc    = 64'h80;
        tick();
        reset             = 1'b0;
        fb.redirect_valid = 1'b0;
        fb.redirect_pc    = 64'h0;
        expect_idle("rr_b1");
        check("rr_pc", fb.if_pc, 64'h0);
        check("rr_raddr", fb.read_address, 64'h0);
        tick(); expect_idle("rr_b2");
        tick(); expect_out("rr0", 64'h0);
        tick(); expect_out("rr4", 64'h4);

        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        expect_idle("wrap_b1");
        check("wrap_raddr0", fb.read_address, 64'h3FFF_FFFF_FFFF_FFFE);
        tick(); check("wrap_raddr1", fb.read_address, 64'h3FFF_FFFF_FFFF_FFFF);
        tick(); expect_out("wrapF8", 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap_raddr2", fb.read_address, 64'h0);
        tick(); expect_out("wrapFC", 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_raddr3", fb.read_address, 64'h1);
        tick(); expect_out("wrap0", 64'h0);
        tick(); expect_out("wrap4", 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
